cpu_run_ctrl: RTL and testbench

Synthesizable run controller for simulation and FPGA bring-up of `cpu`. Sequences the CPU reset for a parametrised number of cycles and counts execution cycles. Snoops the data-memory store bus for writes to a "tohost" mailbox address and reports pass, fail (with code) or timeout. It replaces the hand-timed reset pulse and open-ended run of the current bench, and it can restart a program without a global reset.

---
 rtl/cpu_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for cpu: sequences the CPU reset, counts run cycles and
// snoops the store bus for a tohost mailbox write to report pass/fail/timeout.
module cpu_run_ctrl #(
  parameter int                         DMEM_ADDR_WIDTH = 12,
  parameter int                         DMEM_DATA_WIDTH = 32,
  parameter logic [DMEM_ADDR_WIDTH-1:0] TOHOST_ADDR     = 12'hFFC,
  parameter int                         RST_CYCLES      = 4,
  parameter int                         TIMEOUT_CYCLES  = 100000,
  parameter int                         CNT_WIDTH       = 32,
  parameter bit                         HALT_ON_DONE    = 1'b1
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic                       dmem_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DMEM_DATA_WIDTH-1:0] dmem_wdata,
  output logic                       cpu_rst,
  output logic                       running,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [DMEM_DATA_WIDTH-2:0] fail_code,
  output logic [CNT_WIDTH-1:0]       cycle_count,
  output logic [2:0]                 o_dbg_state
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]          L_HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]       L_TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DMEM_DATA_WIDTH-1:0] L_PASS_VAL     = DMEM_DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [HOLD_W-1:0]          r_hold_cnt;
  logic [HOLD_W-1:0]          w_hold_nxt;
  logic [CNT_WIDTH-1:0]       r_cycle_count;
  logic [CNT_WIDTH-1:0]       w_cycle_nxt;
  logic [DMEM_DATA_WIDTH-2:0] r_fail_code;
  logic [DMEM_DATA_WIDTH-2:0] w_fail_nxt;
  logic                       r_cpu_rst;
  logic                       r_running;
  logic                       r_done;
  logic                       r_pass;
  logic                       r_timeout;
  logic                       w_cpu_rst_nxt;
  logic                       w_mbox_hit;

  assign w_mbox_hit = dmem_we && (dmem_addr == TOHOST_ADDR);

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_HOLD;
      r_hold_cnt    <= '0;
      r_cycle_count <= '0;
      r_fail_code   <= '0;
      r_cpu_rst     <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_cycle_count <= w_cycle_nxt;
      r_fail_code   <= w_fail_nxt;
      r_cpu_rst     <= w_cpu_rst_nxt;
      r_running     <= (w_state_nxt == ST_RUN);
      r_done        <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL) ||
                       (w_state_nxt == ST_TIMEOUT);
      r_pass        <= (w_state_nxt == ST_PASS);
      r_timeout     <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  // Status flags are registered copies decoded from the next state, so every
  // output changes on the same edge as the state it describes.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_cycle_nxt = r_cycle_count;
    w_fail_nxt  = r_fail_code;
    case (r_state)
      ST_HOLD: begin
        if (restart) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == L_HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cycle_count != '1) begin
          w_cycle_nxt = r_cycle_count + 1'b1;
        end
        if (w_mbox_hit && (dmem_wdata == L_PASS_VAL)) begin
          w_state_nxt = ST_PASS;
        end else if (w_mbox_hit && (dmem_wdata != '0)) begin
          w_state_nxt = ST_FAIL;
          w_fail_nxt  = dmem_wdata[DMEM_DATA_WIDTH-1:1];
        end else if (r_cycle_count == L_TIMEOUT_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
    // Restart outside HOLD overrides whatever RUN or a terminal state decided.
    if (restart && (r_state != ST_HOLD)) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = '0;
      w_cycle_nxt = '0;
      w_fail_nxt  = '0;
    end
    case (w_state_nxt)
      ST_HOLD: w_cpu_rst_nxt = 1'b1;
      ST_RUN:  w_cpu_rst_nxt = 1'b0;
      default: w_cpu_rst_nxt = HALT_ON_DONE;
    endcase
  end

  assign cpu_rst     = r_cpu_rst;
  assign running     = r_running;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign fail_code   = r_fail_code;
  assign cycle_count = r_cycle_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed vector table, hand-written corner sequences
// and random stimulus, all scored against a behavioural model of the run flow.
module tb_cpu_run_ctrl;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int CW   = 32;
  localparam int RSTC = 4;
  localparam int TOC  = 20;
  localparam bit HALT = 1'b1;
  localparam int W    = 5 + (DW - 1) + CW;
  localparam logic [AW-1:0] TOHOST = 12'hFFC;

  localparam int R_NONE = 0;
  localparam int R_PASS = 1;
  localparam int R_FAIL = 2;
  localparam int R_TOUT = 3;

  // ---------------- clock / reset ----------------
  logic          sysclk = 1'b0;
  logic          rst = 1'b0;
  logic          restart = 1'b0;
  logic          dmem_we = 1'b0;
  logic [AW-1:0] dmem_addr = '0;
  logic [DW-1:0] dmem_wdata = '0;
  logic          cpu_rst, running, done, pass, timeout;
  logic [DW-2:0] fail_code;
  logic [CW-1:0] cycle_count;
  logic [2:0]    o_dbg_state;

  always #5 sysclk = ~sysclk;

  cpu_run_ctrl #(
    .DMEM_ADDR_WIDTH(AW),
    .DMEM_DATA_WIDTH(DW),
    .TOHOST_ADDR    (TOHOST),
    .RST_CYCLES     (RSTC),
    .TIMEOUT_CYCLES (TOC),
    .CNT_WIDTH      (CW),
    .HALT_ON_DONE   (HALT)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .restart    (restart),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .cpu_rst    (cpu_rst),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail = 0;
  logic [W-1:0]  exp_q[$];

  function automatic logic [W-1:0] pk(bit cr, bit rn, bit dn, bit ps, bit to,
                                       logic [DW-2:0] fc, logic [CW-1:0] cc);
    return {cr, rn, dn, ps, to, fc, cc};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {cpu_rst, running, done, pass, timeout, fail_code, cycle_count};
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks "edges of CPU reset still to go", "run cycles so far" and the
  // sticky result; outputs are derived from those quantities.
  int            m_hold_left;
  longint        m_run;
  int            m_res;
  logic [DW-2:0] m_code;

  function automatic void model_reset();
    m_hold_left = RSTC;
    m_run       = 0;
    m_res       = R_NONE;
    m_code      = '0;
  endfunction

  function automatic void model_step(bit r, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    bit hit;
    hit = we && (a == TOHOST);
    if (m_res == R_NONE && m_hold_left > 0) begin
      m_hold_left = r ? RSTC : m_hold_left - 1;
    end else if (r) begin
      model_reset();
    end else if (m_res == R_NONE) begin
      if (m_run < (longint'(1) << CW) - 1) m_run++;
      if (hit && d == 1) m_res = R_PASS;
      else if (hit && d != 0) begin
        m_res  = R_FAIL;
        m_code = d[DW-1:1];
      end else if (m_run == TOC) m_res = R_TOUT;
    end
  endfunction

  function automatic logic [W-1:0] model_out();
    bit term;
    term = (m_res != R_NONE);
    return pk((m_hold_left > 0) || (term && HALT), (m_hold_left == 0) && !term, term,
              m_res == R_PASS, m_res == R_TOUT, (m_res == R_FAIL) ? m_code : '0,
              CW'(m_run));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit r, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string nm);
    restart    = r;
    dmem_we    = we;
    dmem_addr  = a;
    dmem_wdata = d;
    model_step(r, we, a, d);
    exp_q.push_back(model_out());
    @(posedge sysclk);
    #1;
    check({"model_", nm}, act_vec(), exp_q.pop_front());
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, nm);
  endtask

  // Called 1 time unit after an edge; drops rst between edges.
  task automatic async_reset(input string nm);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check({nm, "_async"}, act_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0));
    #1 rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            r;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit we, logic [AW-1:0] a, logic [DW-1:0] d,
                              logic [W-1:0] exp);
    vec_t v;
    v.r = r; v.we = we; v.a = a; v.d = d; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset release, hold for 4 edges, run, pass at run cycle 10, sticky.
    for (int i = 0; i < 3; i++) add(0, 0, '0, '0, pk(1, 0, 0, 0, 0, '0, '0));
    add(0, 0, '0, '0, pk(0, 1, 0, 0, 0, '0, '0));
    for (int i = 1; i <= 9; i++)
      add(0, i == 2, (i == 2) ? 12'hFF8 : 12'h000, (i == 2) ? 32'd5 : 32'd0,
          pk(0, 1, 0, 0, 0, '0, CW'(i)));
    add(0, 1, TOHOST, 32'd1, pk(1, 0, 1, 1, 0, '0, 32'd10));
    add(0, 1, TOHOST, 32'd7, pk(1, 0, 1, 1, 0, '0, 32'd10));
    add(0, 0, '0, '0, pk(1, 0, 1, 1, 0, '0, 32'd10));
    // Restart from PASS, then a zero store is ignored and 0x2B fails with 0x15.
    add(1, 0, '0, '0, pk(1, 0, 0, 0, 0, '0, '0));
    for (int i = 0; i < 3; i++) add(0, 0, '0, '0, pk(1, 0, 0, 0, 0, '0, '0));
    add(0, 0, '0, '0, pk(0, 1, 0, 0, 0, '0, '0));
    add(0, 1, TOHOST, 32'd0, pk(0, 1, 0, 0, 0, '0, 32'd1));
    add(0, 1, TOHOST, 32'h2B, pk(1, 0, 1, 0, 0, 31'h15, 32'd2));
    add(0, 1, TOHOST, 32'd1, pk(1, 0, 1, 0, 0, 31'h15, 32'd2));

    // ---------------- directed table ----------------
    model_reset();
    #12;
    check("reset_state", act_vec(), pk(1, 0, 0, 0, 0, '0, '0));
    rst = 1'b1;
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d", i), act_vec(), tbl[i].exp);
    end

    // ---------------- timeout after 20 run edges ----------------
    cycle(1, 0, '0, '0, "to_restart");
    idle(RSTC + TOC - 1, "to_run");
    check("to_before", {31'd0, running, timeout, cycle_count}, {31'd0, 1'b1, 1'b0, 32'd19});
    idle(1, "to_edge");
    check("to_hit", {31'd0, timeout, done, cpu_rst, cycle_count},
          {31'd0, 1'b1, 1'b1, 1'b1, 32'd20});

    // ---------------- mailbox beats timeout on cycle 20 ----------------
    cycle(1, 0, '0, '0, "mb_restart");
    idle(RSTC + TOC - 1, "mb_run");
    cycle(0, 1, TOHOST, 32'd1, "mb_edge");
    check("mb_wins", {31'd0, pass, timeout, cycle_count}, {31'd0, 1'b1, 1'b0, 32'd20});

    // ---------------- restart mid-run ----------------
    cycle(1, 0, '0, '0, "mr_restart0");
    idle(RSTC + 5, "mr_run");
    cycle(1, 0, '0, '0, "mr_restart1");
    check("mr_cleared", {30'd0, cpu_rst, running, cycle_count}, {30'd0, 1'b1, 1'b0, 32'd0});
    idle(RSTC, "mr_hold");
    idle(1, "mr_run1");
    check("mr_count1", {30'd0, running, cpu_rst, cycle_count}, {30'd0, 1'b1, 1'b0, 32'd1});

    // ---------------- restart beats mailbox ----------------
    cycle(1, 1, TOHOST, 32'd1, "rm_edge");
    check("rm_hold", {30'd0, cpu_rst, done, cycle_count}, {30'd0, 1'b1, 1'b0, 32'd0});

    // ---------------- restart in HOLD restarts the count ----------------
    idle(2, "rh_hold");
    cycle(1, 0, '0, '0, "rh_restart");
    idle(RSTC - 1, "rh_hold2");
    check("rh_still_rst", {31'd0, cpu_rst, running}, {31'd0, 1'b1, 1'b0});
    idle(1, "rh_run");
    check("rh_running", {31'd0, cpu_rst, running}, {31'd0, 1'b0, 1'b1});

    // ---------------- async reset mid-run ----------------
    idle(3, "ar_run");
    async_reset("ar");
    idle(RSTC, "ar_hold");
    check("ar_rerun", {31'd0, running, cpu_rst}, {31'd0, 1'b1, 1'b0});

    // ---------------- random ----------------
    for (int i = 0; i < 3000; i++) begin
      bit            r, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            sel;
      r   = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 2) == 0);
      a   = ($urandom_range(0, 3) != 0) ? TOHOST : AW'($urandom);
      sel = $urandom_range(0, 5);
      d   = (sel == 0) ? 32'd0 : (sel < 3) ? 32'd1 : $urandom;
      // Keep runs long enough to reach the timeout now and then.
      if ($urandom_range(0, 1) == 0) we = 1'b0;
      cycle(r, we, a, d, "rnd");
      if ($urandom_range(0, 499) == 0) async_reset("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
